// File: rtl/sgd_step_update.sv
// SGD weight update: w_out = sat(w_in - lr * acc / 2^LOG2_SAMPLES), one element per
// cycle through a shared multiplier, stage 1 = product register, stage 2 = shift/sub/sat/write.
module sgd_step_update #(
  parameter int M            = 5,
  parameter int N            = 1,
  parameter int DATA_W       = 16,
  parameter int FRAC         = 8,
  parameter int LOG2_SAMPLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [DATA_W-1:0]   lr,
  input  logic signed [DATA_W-1:0]   w_in  [0:M-1][0:N-1],
  input  logic signed [2*DATA_W-1:0] acc   [0:M-1][0:N-1],
  output logic signed [DATA_W-1:0]   w_out [0:M-1][0:N-1],
  output logic                       busy,
  output logic                       done
);

  localparam int NUM    = M * N;
  localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int PROD_W = 3 * DATA_W;
  localparam int DIFF_W = PROD_W + 1;
  localparam int SHIFT  = FRAC + LOG2_SAMPLES;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  localparam logic signed [DIFF_W-1:0] SAT_MAX =
    {{(DIFF_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] SAT_MIN =
    {{(DIFF_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [IDX_W-1:0]          r_idx;
  logic signed [DATA_W-1:0]  r_lr_q;
  logic                      r_s1_valid;
  logic [IDX_W-1:0]          r_s1_idx;
  logic signed [PROD_W-1:0]  r_s1_prod;
  logic                      r_done;
  logic signed [DATA_W-1:0]  r_w_out [0:NUM-1];

  logic signed [DATA_W-1:0]  w_w_in_flat [0:NUM-1];
  logic signed [ACC_W-1:0]   w_acc_flat  [0:NUM-1];

  logic                      w_issue;
  logic                      w_lr_load;
  logic                      w_last_write;
  logic signed [PROD_W-1:0]  w_acc_ext;
  logic signed [PROD_W-1:0]  w_lr_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  w_step;
  logic signed [DIFF_W-1:0]  w_diff;
  logic signed [DATA_W-1:0]  w_sat;

  // Row-major flattening: element k lives at [k/N][k%N].
  for (genvar k = 0; k < NUM; k++) begin : g_flat
    assign w_w_in_flat[k]  = w_in[k/N][k%N];
    assign w_acc_flat[k]   = acc[k/N][k%N];
    assign w_out[k/N][k%N] = r_w_out[k];
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !r_done)     w_state_nxt = S_RUN;
      S_RUN:   if (r_idx == LAST_IDX)    w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_write)         w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_lr_load = 1'b0;
    case (r_state)
      S_IDLE:  w_lr_load = start && !r_done;
      S_RUN:   w_issue   = 1'b1;
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  // ------------------------------------------------------ index / lr latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx  <= '0;
      r_lr_q <= '0;
    end else if (w_lr_load) begin
      r_idx  <= '0;
      r_lr_q <= lr;
    end else if (w_issue) begin
      r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // ------------------------------------------------------------- stage 1
  assign w_acc_ext = PROD_W'(w_acc_flat[r_idx]);
  assign w_lr_ext  = PROD_W'(r_lr_q);
  assign w_prod    = w_acc_ext * w_lr_ext;

  always_ff @(posedge clk) begin
    if (!reset) r_s1_valid <= 1'b0;
    else        r_s1_valid <= w_issue;
  end

  // Product and index are qualified by r_s1_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_s1_idx  <= r_idx;
      r_s1_prod <= w_prod;
    end
  end

  // ------------------------------------------------------------- stage 2
  // Arithmetic shift floors toward minus infinity; that rounding is intended.
  assign w_step = r_s1_prod >>> SHIFT;
  assign w_diff = DIFF_W'(w_w_in_flat[r_s1_idx]) - DIFF_W'(w_step);

  always_comb begin
    w_sat = w_diff[DATA_W-1:0];
    if (w_diff > SAT_MAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_diff < SAT_MIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  assign w_last_write = r_s1_valid && (r_s1_idx == LAST_IDX);

  // NOTE: w_out is a register bank with a defined cleared state, so it is reset
  // element by element rather than left to power-up contents like a RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM; k++) r_w_out[k] <= '0;
    end else if (r_s1_valid) begin
      r_w_out[r_s1_idx] <= w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= w_last_write;
  end

endmodule

// File: tb/tb_sgd_step_update.sv
// Self-checking bench for sgd_step_update: a timeline model of the update pass is
// compared against the DUT every cycle, plus literal results for known cases.
module tb_sgd_step_update;

  localparam int M    = 3;
  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int L2   = 2;
  localparam int MN   = M * N;

  logic                   clk   = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic signed [DW-1:0]   lr    = '0;
  logic signed [DW-1:0]   w_in  [0:M-1][0:N-1];
  logic signed [2*DW-1:0] acc   [0:M-1][0:N-1];
  logic signed [DW-1:0]   w_out [0:M-1][0:N-1];
  logic                   busy;
  logic                   done;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic signed [DW-1:0] exp_w [0:MN-1];
  logic                 exp_busy = 1'b0;
  logic                 exp_done = 1'b0;

  sgd_step_update #(
    .M(M), .N(N), .DATA_W(DW), .FRAC(FRAC), .LOG2_SAMPLES(L2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .lr    (lr),
    .w_in  (w_in),
    .acc   (acc),
    .w_out (w_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_w(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    check(nm, 32'(a), 32'(e));
  endtask

  // Reference: floor(w - lr*acc / 2^(FRAC+L2)) clamped to the signed DW range.
  function automatic logic signed [DW-1:0] ref_upd(input longint w, input longint a, input longint l);
    longint prod, d, q, diff, hi, lo;
    prod = a * l;
    d    = longint'(1) << (FRAC + L2);
    q    = prod / d;
    if ((prod % d) != 0 && prod < 0) q = q - 1;
    diff = w - q;
    hi   = (longint'(1) << (DW - 1)) - 1;
    lo   = -(longint'(1) << (DW - 1));
    if (diff > hi)      diff = hi;
    else if (diff < lo) diff = lo;
    return DW'(diff);
  endfunction

  // Timeline model: start accepted at edge 0, element k written at edge k+2,
  // done at edge MN+1, busy covers edges 0..MN+1.
  initial begin
    int  m_t;
    int  k;
    bit  m_active;
    bit  was_done;
    logic signed [DW-1:0] m_lr;
    m_t = 0; m_active = 1'b0; m_lr = '0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int e = 0; e < MN; e++) exp_w[e] = '0;
        m_active = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
      end else begin
        was_done = exp_done;
        exp_done = 1'b0;
        if (m_active) begin
          m_t++;
          k = m_t - 2;
          if (k >= 0 && k < MN)
            exp_w[k] = ref_upd(longint'(w_in[k/N][k%N]), longint'(acc[k/N][k%N]), longint'(m_lr));
          if (m_t == MN + 1) begin
            m_active = 1'b0;
            exp_done = 1'b1;
          end
        end else if (start && !was_done) begin
          m_active = 1'b1;
          m_t      = 0;
          m_lr     = lr;
        end
        exp_busy = m_active;
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            check_w($sformatf("w_out[%0d][%0d]", i, j), w_out[i][j], exp_w[i*N+j]);
      end
    end
  end

  task automatic fill_random();
    logic [31:0] r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        w_in[i][j] = DW'($urandom);
        r          = $urandom;
        acc[i][j]  = $signed(r) >>> $urandom_range(0, 24);
      end
  endtask

  // Start a pass, optionally poking start/lr or reset at a given cycle, and wait
  // (bounded) for done. cyc counts falling edges after the start-sampling edge+1.
  task automatic run_pass(input logic signed [DW-1:0] lr_v, input int poke_at,
                          input bit poke_rst, input int max_cyc,
                          output bit saw_done, output int cyc);
    @(negedge clk);
    start    = 1'b1;
    lr       = lr_v;
    cyc      = 0;
    saw_done = 1'b0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      reset = 1'b1;
      if (done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      if (cyc == poke_at) begin
        if (poke_rst) reset = 1'b0;
        else begin
          start = 1'b1;
          lr    = ~lr_v;
        end
      end
    end
  endtask

  initial begin
    bit saw;
    int cyc;
    int tmp;
    logic [DW-1:0] lit [0:MN-1];

    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        w_in[i][j] = '0;
        acc[i][j]  = '0;
      end

    reset = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check_w("reset_w_out00", w_out[0][0], 16'h0000);
    reset = 1'b1;

    // Basic step in element 1, matrix ramp elsewhere, restart + lr change at edge 3.
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j]  = 32'h400 * (i*N + j);
        w_in[i][j] = 16'h1000;
      end
    w_in[0][1] = 16'h0100;
    run_pass(16'sh0080, 3, 1'b0, 40, saw, cyc);
    check("p1_done_seen", 32'(saw), 32'd1);
    check("p1_latency", 32'(cyc), 32'(MN + 2));
    lit = '{16'h1000, 16'h0080, 16'h0F00, 16'h0E80, 16'h0E00, 16'h0D80};
    for (int k = 0; k < MN; k++)
      check_w($sformatf("p1_lit[%0d]", k), w_out[k/N][k%N], lit[k]);

    // start while done is high must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_during_done", 32'(busy), 32'd0);

    // Saturation both ways.
    fill_random();
    w_in[0][0] = 16'sh7F00; acc[0][0] = 32'shFFFF8000;
    w_in[0][1] = 16'sh8100; acc[0][1] = 32'sh00008000;
    run_pass(16'sh0100, 0, 1'b0, 40, saw, cyc);
    check("p2_done_seen", 32'(saw), 32'd1);
    check_w("sat_pos", w_out[0][0], 16'h7FFF);
    check_w("sat_neg", w_out[0][1], 16'h8000);

    // Floor rounding.
    fill_random();
    w_in[0][0] = '0; acc[0][0] = 32'shFFFFFFFF;
    w_in[0][1] = '0; acc[0][1] = 32'sh00000001;
    run_pass(16'sh0001, 0, 1'b0, 40, saw, cyc);
    check("p3_done_seen", 32'(saw), 32'd1);
    check_w("floor_neg", w_out[0][0], 16'h0001);
    check_w("floor_pos", w_out[0][1], 16'h0000);

    // Reset at edge 3 of a pass: no done, everything cleared, then a clean pass.
    fill_random();
    run_pass(16'sh0123, 3, 1'b1, 12, saw, cyc);
    check("reset_no_done", 32'(saw), 32'd0);
    check("reset_busy_low", 32'(busy), 32'd0);
    for (int k = 0; k < MN; k++)
      check_w($sformatf("reset_clr[%0d]", k), w_out[k/N][k%N], 16'h0000);
    run_pass(16'sh0040, 0, 1'b0, 40, saw, cyc);
    check("post_reset_done", 32'(saw), 32'd1);
    check("post_reset_latency", 32'(cyc), 32'(MN + 2));

    // Randomized passes; the per-cycle model carries the checking.
    for (int p = 0; p < 14; p++) begin
      fill_random();
      if (p % 3 == 0) tmp = int'($urandom);
      else            tmp = int'($urandom_range(0, 1023)) - 512;
      run_pass(DW'(tmp), (p % 4 == 1) ? 2 : 0, 1'b0, 40, saw, cyc);
      check($sformatf("rand%0d_done", p), 32'(saw), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sgd_step_update.md
Name: sgd_step_update

Overview:
- Downstream consumer of the gradient accumulators: takes an M x N accumulated gradient matrix (sum over SAMPLES samples) and the current weight matrix, and produces updated weights w_new = sat(w - lr * acc / SAMPLES).
- One instance per weight or bias matrix. It starts once the batch accumulation completes and signals done before the accumulator clears.
- Elements are processed serially through one shared multiplier with a 2-stage pipeline.

Parameters:
- M, 5, rows of the matrix.
- N, 1, columns of the matrix.
- DATA_W, 16, signed weight / learning-rate width (data_type).
- FRAC, 8, fractional bits of data_type. Accumulated values carry the same FRAC.
- LOG2_SAMPLES, 1, log2 of the batch size. The batch size is always a power of two, so the divide is a shift.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle request to begin an update pass
- lr  in  DATA_W  signed learning rate, FRAC fractional bits
- w_in  in  [0:M-1][0:N-1] x DATA_W  current weights (signed)
- acc  in  [0:M-1][0:N-1] x 2*DATA_W  accumulated gradients (signed, double_data_type)
- w_out  out  [0:M-1][0:N-1] x DATA_W  updated weights, registered
- busy  out  1  high from the first RUN cycle until done
- done  out  1  one-cycle pulse; pass complete

Behaviour:
- Reset (reset==0 at a clk edge):
  - All w_out elements go to 0; busy=0, done=0.
  - The FSM goes to IDLE, the index counter to 0, and the pipeline valids are cleared.
  - Reset has priority over every other input and aborts any pass in progress; partially written w_out is cleared.
- FSM has states IDLE, RUN, DRAIN.
  - IDLE: when start=1, latch lr into lr_q, set idx=0 and go to RUN. Otherwise stay; w_out holds.
  - RUN: each cycle, issue element idx (row-major, idx = i*N + j) into stage 1, then increment idx. After issuing idx = M*N-1, go to DRAIN.
  - DRAIN: wait until stage 2 has written the last element. Assert done for exactly that cycle, then return to IDLE.
- Pipeline:
  - Stage 1 registers prod = acc[i][j] * lr_q (signed, 3*DATA_W bits, 2*FRAC fractional bits) together with its index and a valid bit.
  - Stage 2 computes step = prod >>> (FRAC + LOG2_SAMPLES). The shift is arithmetic, so rounding is floor toward minus infinity.
  - Stage 2 then computes diff = w_in[i][j] - step at full width.
  - Stage 2 saturates diff to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1] and writes the result to w_out[i][j].
- Timing, with the start-sampling edge as edge 0:
  - Element k enters stage 1 at edge k+1 and is written to w_out at edge k+2.
  - The last write and done both occur at edge M*N+1.
  - busy goes high at edge 0 and low at edge M*N+1, the same edge at which done rises.
- start while busy or while done=1 is ignored; there is no queueing.
- w_in and acc must be held stable while busy=1, because upstream accumulation is disabled during the pass.
  - lr is sampled only at start; changes to it during a pass have no effect.
- M*N = 1 is legal: a single RUN cycle, then DRAIN, with done at edge 2.
- Elements not yet written in a pass keep their previous w_out value.
- The w_out register updates only on the stage-2 valid write.

Test Plan:
1. Basic step. M=N=1, FRAC=8, LOG2_SAMPLES=2, lr=0x0080, acc=0x00000400, w_in=0x0100, pulse start.
   -> w_out=0x0080, done high exactly at edge 2, busy high for edges 0..1.
2. Positive saturation. w_in=0x7F00, acc=0xFFFF8000, lr=0x0100, LOG2_SAMPLES=2.
   -> step=-0x2000, w_out=0x7FFF.
   Negative mirror: w_in=0x8100, acc=0x00008000 -> w_out=0x8000.
3. Floor rounding. w_in=0x0000, acc=0xFFFFFFFF, lr=0x0001.
   -> step=-1, w_out=0x0001.
   With acc=0x00000001 -> step=0, w_out=0x0000.
4. Matrix order and latency. M=3, N=2, acc[i][j]=0x400*(i*N+j), lr=0x0080, LOG2_SAMPLES=2, w_in all 0x1000.
   -> w_out[i][j] = 0x1000 - 0x80*(i*N+j), written in row-major order at edges 2..7, done at edge 7, one pulse.
5. Protocol.
   - Pulse start again at edge 3 of a running pass, and change lr mid-pass -> no restart, results use the original lr.
   - A new start in the cycle after done -> a second pass runs normally.
6. Reset mid-operation. Drive reset=0 at edge 3 of a 6-element pass.
   -> next cycle: all w_out=0, busy=0, done never pulses.
   -> a start after reset release completes a full pass with correct values.
